// File: rtl/cv32e40p_nmr_voter_mon.sv
// ============================================================================
// cv32e40p_nmr_voter_mon
//
// Purpose:
//   Votes over NUM_LANES redundant copies of a data word. It also watches
//   every lane for disagreement with the majority and isolates a lane once it
//   has disagreed often enough. Each isolation is reported through a small
//   valid/ready handshake. An isolation that cannot be reported because a
//   report is already waiting sets a sticky overflow flag.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   valid_i            lane words form a sample this cycle
//   lane_data_i        lane k at bits [k*WIDTH +: WIDTH]
//   mode_i             0 VOTE, 1 DETECT, 2/3 BYPASS
//   clear_i            clears counters, isolation flags and overflow flag
//   result_o           registered voted word
//   result_valid_o     result_o holds a new sample
//   mismatch_o         some active lane disagreed in that sample
//   no_majority_o      a bit tie was resolved in that sample
//   lane_iso_o         sticky per-lane isolation flags
//   err_valid_o        isolation report pending
//   err_ready_i        consumer accepts the pending report
//   err_lane_o         lane index carried by the pending report
//   err_overflow_o     sticky: an isolation report was dropped
// ============================================================================
module cv32e40p_nmr_voter_mon #(
    parameter int WIDTH      = 32,
    parameter int NUM_LANES  = 3,
    parameter int CNT_W      = 4,
    parameter int ISO_THRESH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_i,
    input  logic [NUM_LANES*WIDTH-1:0]   lane_data_i,
    input  logic [1:0]                   mode_i,
    input  logic                         clear_i,
    output logic [WIDTH-1:0]             result_o,
    output logic                         result_valid_o,
    output logic                         mismatch_o,
    output logic                         no_majority_o,
    output logic [NUM_LANES-1:0]         lane_iso_o,
    output logic                         err_valid_o,
    input  logic                         err_ready_i,
    output logic [$clog2(NUM_LANES)-1:0] err_lane_o,
    output logic                         err_overflow_o
);

    localparam int              LIDX_W    = $clog2(NUM_LANES);
    localparam int              CNT_LW    = $clog2(NUM_LANES + 1);
    localparam logic [1:0]      MODE_VOTE = 2'd0;
    localparam logic [1:0]      MODE_DET  = 2'd1;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ISO_TH   = CNT_W'(ISO_THRESH);

    typedef enum logic {
        IDLE,
        PEND
    } report_state_e;

    report_state_e state_q, state_d;

    logic [NUM_LANES-1:0]            lane_iso_q, lane_iso_d;
    logic [NUM_LANES-1:0][CNT_W-1:0] cnt_q, cnt_d, cntInc;
    logic [LIDX_W-1:0]               err_lane_q, err_lane_d;
    logic                            err_ovf_q, err_ovf_d;
    logic [WIDTH-1:0]                result_q;
    logic                            result_valid_q, mismatch_q, no_majority_q;

    logic [NUM_LANES-1:0] activeLanes;
    logic [CNT_LW-1:0]    activeCnt;
    logic [CNT_LW-1:0]    onesCnt;
    logic [WIDTH-1:0]     lowWord;
    logic                 lowFound;
    logic [WIDTH-1:0]     majWord;
    logic                 tieAny;
    logic [NUM_LANES-1:0] disagree;
    logic                 countEn;
    logic [NUM_LANES-1:0] isoCand;
    logic [NUM_LANES-1:0] isoMask;
    logic [LIDX_W-1:0]    isoLane;
    logic                 isoFound;
    logic                 isoEvent;
    logic                 errLaneLoad;
    logic                 ovfSet;

    assign activeLanes = ~lane_iso_q;

    // Count the lanes that still take part in voting. Isolation never lets
    // this drop below two.
    always_comb begin
        activeCnt = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            activeCnt = activeCnt + CNT_LW'(activeLanes[k]);
        end
    end

    // The lowest-index active lane supplies the bit value whenever the
    // remaining lanes split evenly on a bit.
    always_comb begin
        lowWord  = lane_data_i[WIDTH-1:0];
        lowFound = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (activeLanes[k] && !lowFound) begin
                lowWord  = lane_data_i[k*WIDTH +: WIDTH];
                lowFound = 1'b1;
            end
        end
    end

    // Bitwise majority over the active lanes. A bit is set when more than
    // half of the active lanes have it set. An exact half is a tie, which is
    // resolved from lowWord and flagged.
    always_comb begin
        majWord = '0;
        tieAny  = 1'b0;
        onesCnt = '0;
        for (int b = 0; b < WIDTH; b++) begin
            onesCnt = '0;
            for (int k = 0; k < NUM_LANES; k++) begin
                if (activeLanes[k]) begin
                    onesCnt = onesCnt + CNT_LW'(lane_data_i[k*WIDTH + b]);
                end
            end
            if ({onesCnt, 1'b0} > {1'b0, activeCnt}) begin
                majWord[b] = 1'b1;
            end else if ({onesCnt, 1'b0} == {1'b0, activeCnt}) begin
                majWord[b] = lowWord[b];
                tieAny     = 1'b1;
            end
        end
    end

    // A lane disagrees when it is active and its word differs from the
    // majority word. This check runs in every mode, so mismatch_o is
    // meaningful in DETECT and BYPASS as well.
    always_comb begin
        disagree = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            disagree[k] = activeLanes[k] &&
                          (lane_data_i[k*WIDTH +: WIDTH] != majWord);
        end
    end

    // Per-lane saturating counters advance only in VOTE and DETECT.
    // Isolation candidates are judged on the post-increment values, so the
    // sample that reaches the threshold is the one that isolates the lane.
    always_comb begin
        countEn = valid_i && ((mode_i == MODE_VOTE) || (mode_i == MODE_DET));
        cntInc  = cnt_q;
        isoCand = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (countEn && disagree[k] && (cnt_q[k] != CNT_MAX)) begin
                cntInc[k] = cnt_q[k] + CNT_W'(1);
            end
            isoCand[k] = activeLanes[k] && (cntInc[k] >= ISO_TH);
        end
    end

    // Pick the lowest-index candidate. Only one lane is isolated per cycle.
    // Other candidates wait for a later disagreeing sample. A same-cycle
    // clear wins, and a two-lane voter is never reduced further.
    always_comb begin
        isoLane  = '0;
        isoMask  = '0;
        isoFound = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (isoCand[k] && !isoFound) begin
                isoLane    = LIDX_W'(k);
                isoMask[k] = 1'b1;
                isoFound   = 1'b1;
            end
        end
        isoEvent = valid_i && (mode_i == MODE_VOTE) && !clear_i &&
                   (activeCnt > CNT_LW'(2)) && isoFound;
    end

    // Next values of the counters, isolation flags and overflow flag.
    // clear_i overrides anything that happens in the same cycle.
    always_comb begin
        if (clear_i) begin
            cnt_d      = '0;
            lane_iso_d = '0;
            err_ovf_d  = 1'b0;
        end else begin
            cnt_d      = cntInc;
            lane_iso_d = lane_iso_q | (isoEvent ? isoMask : '0);
            err_ovf_d  = err_ovf_q | ovfSet;
        end
    end

    // Report FSM next state. An acceptance and a new isolation in the same
    // cycle reload the report instead of dropping it. A new isolation with
    // no acceptance is lost and counted as an overflow.
    always_comb begin
        state_d     = state_q;
        errLaneLoad = 1'b0;
        ovfSet      = 1'b0;
        case (state_q)
            IDLE: begin
                if (isoEvent) begin
                    state_d     = PEND;
                    errLaneLoad = 1'b1;
                end
            end
            PEND: begin
                if (err_ready_i) begin
                    if (isoEvent) begin
                        errLaneLoad = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (isoEvent) begin
                    ovfSet = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        err_lane_d = errLaneLoad ? isoLane : err_lane_q;
    end

    // Report FSM outputs. A report is visible exactly while in PEND.
    always_comb begin
        err_valid_o = (state_q == PEND);
    end

    // State registers for the report FSM and the lane-health bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            err_lane_q <= '0;
            err_ovf_q  <= 1'b0;
            lane_iso_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            err_lane_q <= err_lane_d;
            err_ovf_q  <= err_ovf_d;
            lane_iso_q <= lane_iso_d;
            cnt_q      <= cnt_d;
        end
    end

    // Registered result path. The word holds when no sample arrives, while
    // the per-sample flags drop back to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q       <= '0;
            result_valid_q <= 1'b0;
            mismatch_q     <= 1'b0;
            no_majority_q  <= 1'b0;
        end else if (valid_i) begin
            result_q       <= (mode_i == MODE_VOTE) ? majWord
                                                    : lane_data_i[WIDTH-1:0];
            result_valid_q <= 1'b1;
            mismatch_q     <= |disagree;
            no_majority_q  <= (mode_i == MODE_VOTE) && tieAny;
        end else begin
            result_valid_q <= 1'b0;
            mismatch_q     <= 1'b0;
            no_majority_q  <= 1'b0;
        end
    end

    assign result_o       = result_q;
    assign result_valid_o = result_valid_q;
    assign mismatch_o     = mismatch_q;
    assign no_majority_o  = no_majority_q;
    assign lane_iso_o     = lane_iso_q;
    assign err_lane_o     = err_lane_q;
    assign err_overflow_o = err_ovf_q;

endmodule

// File: tb/tb_cv32e40p_nmr_voter_mon.sv
// ============================================================================
// tb_cv32e40p_nmr_voter_mon
//
// Drives a 3-lane and a 5-lane voter from one stimulus task. A behavioural
// model predicts each sample's voted word and flags when the stimulus is
// applied. Those predictions queue up and are compared when the DUT raises
// result_valid_o. Isolation, report and overflow state is compared against
// the model every cycle.
// ============================================================================
module tb_cv32e40p_nmr_voter_mon;

    localparam int W    = 32;
    localparam int ISO  = 4;
    localparam int CMAX = 15;

    typedef struct {
        logic [W-1:0] res;
        logic         mm;
        logic         nm;
    } expItem_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic         valid3 = 1'b0, clear3 = 1'b0, ready3 = 1'b0;
    logic [1:0]   mode3  = 2'd0;
    logic [3*W-1:0] lanes3 = '0;
    logic [W-1:0] res3;
    logic         rv3, mm3, nm3, ev3, ovf3;
    logic [2:0]   iso3;
    logic [1:0]   el3;

    logic         valid5 = 1'b0, clear5 = 1'b0, ready5 = 1'b0;
    logic [1:0]   mode5  = 2'd0;
    logic [5*W-1:0] lanes5 = '0;
    logic [W-1:0] res5;
    logic         rv5, mm5, nm5, ev5, ovf5;
    logic [4:0]   iso5;
    logic [2:0]   el5;

    int vectorCount = 0;
    int missCount   = 0;
    logic checking  = 1'b0;

    expItem_t q3[$];
    expItem_t q5[$];

    logic [4:0]   mIso [2];
    int           mCnt [2][5];
    logic         mPend[2];
    int           mLane[2];
    logic         mOvf [2];
    logic         mRv  [2];
    logic [W-1:0] mRes [2];

    always #5 clk = ~clk;

    cv32e40p_nmr_voter_mon #(
        .WIDTH(W), .NUM_LANES(3), .CNT_W(4), .ISO_THRESH(ISO)
    ) u3 (
        .clk(clk), .rst(rst), .valid_i(valid3), .lane_data_i(lanes3),
        .mode_i(mode3), .clear_i(clear3), .result_o(res3),
        .result_valid_o(rv3), .mismatch_o(mm3), .no_majority_o(nm3),
        .lane_iso_o(iso3), .err_valid_o(ev3), .err_ready_i(ready3),
        .err_lane_o(el3), .err_overflow_o(ovf3)
    );

    cv32e40p_nmr_voter_mon #(
        .WIDTH(W), .NUM_LANES(5), .CNT_W(4), .ISO_THRESH(ISO)
    ) u5 (
        .clk(clk), .rst(rst), .valid_i(valid5), .lane_data_i(lanes5),
        .mode_i(mode5), .clear_i(clear5), .result_o(res5),
        .result_valid_o(rv5), .mismatch_o(mm5), .no_majority_o(nm5),
        .lane_iso_o(iso5), .err_valid_o(ev5), .err_ready_i(ready5),
        .err_lane_o(el5), .err_overflow_o(ovf5)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] act,
                               input logic [63:0] exp);
        vectorCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [5*W-1:0] pk(input logic [W-1:0] a, b, c,
                                          input logic [W-1:0] d, e);
        return {e, d, c, b, a};
    endfunction

    // Reference behaviour for one clock edge of instance i (0: 3 lanes,
    // 1: 5 lanes), applied when the stimulus for that edge is driven.
    task automatic modelStep(input int i, input logic r, input logic v,
                             input logic [1:0] m, input logic c,
                             input logic rd, input logic [5*W-1:0] lanes);
        int nl, act, ones, first, evLane;
        int newCnt[5];
        logic [W-1:0] maj, w;
        logic tie, ev;
        logic [4:0] dis;
        expItem_t e;
        nl = (i == 0) ? 3 : 5;
        if (r) begin
            mIso[i] = '0; mPend[i] = 1'b0; mLane[i] = 0; mOvf[i] = 1'b0;
            mRv[i] = 1'b0; mRes[i] = '0;
            for (int k = 0; k < 5; k++) mCnt[i][k] = 0;
            if (i == 0) q3.delete(); else q5.delete();
        end else begin
            act = 0;
            for (int k = 0; k < nl; k++) if (!mIso[i][k]) act++;
            maj = '0; tie = 1'b0;
            for (int b = 0; b < W; b++) begin
                ones = 0; first = -1;
                for (int k = 0; k < nl; k++) begin
                    if (!mIso[i][k]) begin
                        w = lanes[k*W +: W];
                        if (w[b]) ones++;
                        if (first < 0) first = k;
                    end
                end
                w = lanes[first*W +: W];
                if (2*ones > act) maj[b] = 1'b1;
                else if (2*ones == act) begin maj[b] = w[b]; tie = 1'b1; end
            end
            dis = '0;
            for (int k = 0; k < nl; k++)
                dis[k] = !mIso[i][k] && (lanes[k*W +: W] != maj);
            if (v) begin
                e.res = (m == 2'd0) ? maj : lanes[W-1:0];
                e.mm  = |dis;
                e.nm  = (m == 2'd0) && tie;
                if (i == 0) q3.push_back(e); else q5.push_back(e);
                mRv[i]  = 1'b1;
                mRes[i] = e.res;
            end else begin
                mRv[i] = 1'b0;
            end
            for (int k = 0; k < 5; k++) begin
                newCnt[k] = mCnt[i][k];
                if (v && m < 2 && dis[k] && newCnt[k] < CMAX) newCnt[k]++;
            end
            ev = 1'b0; evLane = 0;
            if (v && m == 2'd0 && !c && act > 2)
                for (int k = 0; k < nl; k++)
                    if (!ev && !mIso[i][k] && newCnt[k] >= ISO) begin
                        ev = 1'b1; evLane = k;
                    end
            if (mPend[i]) begin
                if (rd) begin
                    if (ev) mLane[i] = evLane; else mPend[i] = 1'b0;
                end else if (ev) mOvf[i] = 1'b1;
            end else if (ev) begin
                mPend[i] = 1'b1; mLane[i] = evLane;
            end
            if (ev) mIso[i][evLane] = 1'b1;
            if (c) begin
                mIso[i] = '0; mOvf[i] = 1'b0;
                for (int k = 0; k < 5; k++) mCnt[i][k] = 0;
            end else begin
                for (int k = 0; k < 5; k++) mCnt[i][k] = newCnt[k];
            end
        end
    endtask

    // Drive one cycle of stimulus into instance inst, holding the other one
    // idle, and advance the model of both accordingly.
    task automatic applyStimulus(input int inst, input logic r, input logic v,
                                 input logic [1:0] m, input logic c,
                                 input logic rd, input logic [5*W-1:0] lanes);
        @(negedge clk);
        rst = r;
        if (inst == 0) begin
            valid3 = v; mode3 = m; clear3 = c; ready3 = rd;
            lanes3 = lanes[3*W-1:0];
            valid5 = 1'b0; clear5 = 1'b0; ready5 = 1'b0;
        end else begin
            valid5 = v; mode5 = m; clear5 = c; ready5 = rd; lanes5 = lanes;
            valid3 = 1'b0; clear3 = 1'b0; ready3 = 1'b0;
        end
        modelStep(inst, r, v, m, c, rd, lanes);
        modelStep(1 - inst, r, 1'b0, 2'd0, 1'b0, 1'b0, '0);
    endtask

    // Monitor: after each edge, pop the scoreboard on a valid result and
    // compare the persistent state against the model.
    always @(posedge clk) begin
        expItem_t e;
        #2;
        if (checking) begin
            checkOutput("u3 result_valid", rv3, mRv[0]);
            if (rv3) begin
                if (q3.size() == 0) checkOutput("u3 sb depth", q3.size(), 1);
                else begin
                    e = q3.pop_front();
                    checkOutput("u3 result", res3, e.res);
                    checkOutput("u3 mismatch", mm3, e.mm);
                    checkOutput("u3 no_majority", nm3, e.nm);
                end
            end else checkOutput("u3 result hold", res3, mRes[0]);
            checkOutput("u3 lane_iso", iso3, mIso[0][2:0]);
            checkOutput("u3 err_valid", ev3, mPend[0]);
            if (mPend[0]) checkOutput("u3 err_lane", el3, mLane[0]);
            checkOutput("u3 overflow", ovf3, mOvf[0]);

            checkOutput("u5 result_valid", rv5, mRv[1]);
            if (rv5) begin
                if (q5.size() == 0) checkOutput("u5 sb depth", q5.size(), 1);
                else begin
                    e = q5.pop_front();
                    checkOutput("u5 result", res5, e.res);
                    checkOutput("u5 mismatch", mm5, e.mm);
                    checkOutput("u5 no_majority", nm5, e.nm);
                end
            end else checkOutput("u5 result hold", res5, mRes[1]);
            checkOutput("u5 lane_iso", iso5, mIso[1]);
            checkOutput("u5 err_valid", ev5, mPend[1]);
            if (mPend[1]) checkOutput("u5 err_lane", el5, mLane[1]);
            checkOutput("u5 overflow", ovf5, mOvf[1]);
        end
    end

    localparam logic [W-1:0] A  = 32'hA5A5A5A5;
    localparam logic [W-1:0] F  = 32'hFFFFFFFF;
    localparam logic [W-1:0] L0 = 32'h12345678;
    localparam logic [W-1:0] L1 = 32'h87654321;
    localparam logic [W-1:0] BD = 32'h0F0F0F0F;
    localparam logic [W-1:0] DB = 32'hDEADBEEF;
    localparam logic [W-1:0] C  = 32'h3C3C3C3C;
    localparam logic [W-1:0] X1 = 32'h11111111;
    localparam logic [W-1:0] X3 = 32'h33333333;
    localparam logic [W-1:0] X4 = 32'h44444444;

    initial begin
        logic [W-1:0] base;
        logic [W-1:0] wv[5];

        applyStimulus(0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, '0);
        checking = 1'b1;
        applyStimulus(0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, '0);

        // 3 lanes: lane 2 faulty, isolated on the fourth sample.
        for (int n = 0; n < 4; n++)
            applyStimulus(0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, pk(A, A, F, 0, 0));
        applyStimulus(0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, '0);
        applyStimulus(0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, '0);
        applyStimulus(0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, '0);

        // Two active lanes disagreeing: ties, no further isolation.
        for (int n = 0; n < 5; n++)
            applyStimulus(0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, pk(L0, L1, F, 0, 0));
        applyStimulus(0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, pk(L0, L1, F, 0, 0));

        // Clear, then a threshold-crossing sample coinciding with clear.
        applyStimulus(0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, '0);
        for (int n = 0; n < 3; n++)
            applyStimulus(0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, pk(A, BD, A, 0, 0));
        applyStimulus(0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, pk(A, BD, A, 0, 0));
        for (int n = 0; n < 4; n++)
            applyStimulus(0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, pk(A, BD, A, 0, 0));

        // BYPASS freezes counters; DETECT counts but never isolates.
        applyStimulus(0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, '0);
        for (int n = 0; n < 3; n++)
            applyStimulus(0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, pk(DB, 0, 0, 0, 0));
        for (int n = 0; n < 2; n++)
            applyStimulus(0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1, pk(DB, 0, 0, 0, 0));
        applyStimulus(0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, pk(DB, 0, 0, 0, 0));
        for (int n = 0; n < 2; n++)
            applyStimulus(0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, pk(DB, 0, 0, 0, 0));
        applyStimulus(0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, pk(DB, 0, 0, 0, 0));
        applyStimulus(0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, '0);
        applyStimulus(0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, '0);
        applyStimulus(0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, '0);

        // 5 lanes: lanes 1 and 3 reach the threshold together.
        for (int n = 0; n < 5; n++)
            applyStimulus(1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, pk(C, X1, C, X3, C));
        // Lane 4 isolated in the same cycle the pending report is accepted.
        for (int n = 0; n < 3; n++)
            applyStimulus(1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, pk(C, X1, C, X3, X4));
        applyStimulus(1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, pk(C, X1, C, X3, X4));
        applyStimulus(1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, '0);

        // Random traffic on both instances.
        for (int n = 0; n < 8; n++) begin
            base = $urandom;
            for (int k = 0; k < 5; k++)
                wv[k] = ($urandom_range(0, 3) == 0) ? $urandom : base;
            applyStimulus(n % 2, 1'b0, 1'b1, 2'($urandom_range(0, 3)), 1'b0,
                          1'($urandom_range(0, 1)),
                          pk(wv[0], wv[1], wv[2], wv[3], wv[4]));
        end
        applyStimulus(1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, '0);
        applyStimulus(0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, '0);
        applyStimulus(0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, '0);

        @(posedge clk);
        #3;
        checking = 1'b0;
        checkOutput("u3 sb leftover", q3.size(), 0);
        checkOutput("u5 sb leftover", q5.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/cv32e40p_nmr_voter_mon.md
CV32E40P_NMR_VOTER_MON -- requirements
Module: cv32e40p_nmr_voter_mon

Interface
REQ-001 Parameter WIDTH, default 32: data width of each redundant lane.
REQ-002 Parameter NUM_LANES, default 3: number of redundant lanes; legal values 3 and 5 only.
REQ-003 Parameter CNT_W, default 4: width of each per-lane mismatch counter.
REQ-004 Parameter ISO_THRESH, default 4: mismatch count at which a lane is isolated; legal range 1..2^CNT_W-1.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 valid_i  in  1  the lane words this cycle form a sample to vote.
REQ-008 lane_data_i  in  NUM_LANES*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
REQ-009 mode_i  in  2  operating mode: 0 VOTE, 1 DETECT, 2 BYPASS; 3 is treated as BYPASS.
REQ-010 clear_i  in  1  clears counters, isolation flags and the overflow flag.
REQ-011 result_o  out  WIDTH  registered voted word.
REQ-012 result_valid_o  out  1  result_o holds a new sample.
REQ-013 mismatch_o  out  1  registered: at least one active lane disagreed in that sample.
REQ-014 no_majority_o  out  1  registered: a bit tie occurred in that sample.
REQ-015 lane_iso_o  out  NUM_LANES  sticky per-lane isolation flags.
REQ-016 err_valid_o  out  1  an isolation event report is pending.
REQ-017 err_ready_i  in  1  consumer accepts the pending report.
REQ-018 err_lane_o  out  $clog2(NUM_LANES)  index of the isolated lane in the pending report.
REQ-019 err_overflow_o  out  1  sticky: an isolation event was dropped while a report was pending.

Function
REQ-020 Active lanes are those with lane_iso_o=0; the active-lane count is never less than 2.
REQ-021 VOTE mode: each result bit is the strict majority over the active lanes.
REQ-022 VOTE mode bit tie (even active count): the bit takes the lowest-index active lane's value, and no_majority_o=1 for that sample.
REQ-023 DETECT and BYPASS modes: result is lane 0's word, no_majority_o=0.
REQ-024 Latency: valid_i at cycle N gives result_o, result_valid_o=1, mismatch_o and no_majority_o at cycle N+1.
REQ-025 When valid_i=0, result_valid_o=0 next cycle and result_o holds its previous value.
REQ-026 A lane disagrees when it is active and its word differs from the bitwise majority over the active lanes; this comparison is mode-independent.
REQ-027 VOTE and DETECT modes: on each valid sample, each disagreeing lane's counter increments, saturating at 2^CNT_W-1.
REQ-028 BYPASS mode: counters are frozen.
REQ-029 Isolation applies in VOTE mode only and is evaluated on each valid sample using the post-increment counters.
REQ-030 Isolation candidates are active lanes whose counter is >= ISO_THRESH.
REQ-031 At most one lane is isolated per cycle: the lowest-index candidate; the remaining candidates are re-evaluated on later samples.
REQ-032 Isolation is suppressed when the active-lane count is 2.
REQ-033 Report FSM has two states, IDLE and PEND.
REQ-034 IDLE to PEND on an isolation; err_lane_o is loaded with the isolated lane index.
REQ-035 PEND holds err_valid_o=1 with err_lane_o stable until err_ready_i=1, then returns to IDLE.
REQ-036 Isolation while in PEND without acceptance: the event is dropped and err_overflow_o is set.
REQ-037 Isolation in the same cycle as acceptance: the FSM reloads err_lane_o and stays in PEND; no overflow.
REQ-038 clear_i zeroes counters, lane_iso_o and err_overflow_o; clear_i has priority over a same-cycle increment or isolation.
REQ-039 clear_i does not affect the voted result or the report FSM.
REQ-040 A mode_i change takes effect on the next valid sample; isolation state persists across mode changes.

Reset
REQ-041 rst=1 at a clock edge: result_o=0, result_valid_o=0, mismatch_o=0, no_majority_o=0, lane_iso_o=0, counters=0, err_valid_o=0, err_lane_o=0, err_overflow_o=0, FSM to IDLE.
REQ-042 Reset mid-operation discards any pending report; rst has priority over all other inputs.

Verification
REQ-043 Scenario 1: NUM_LANES=3, VOTE, lanes 0xA5A5A5A5, 0xA5A5A5A5, 0xFFFFFFFF -> next cycle result_o=0xA5A5A5A5, mismatch_o=1, lane 2 counter=1.
REQ-044 Scenario 2: 4 such samples, ISO_THRESH=4 -> lane_iso_o=3'b100, err_valid_o=1, err_lane_o=2; later samples with lanes 0/1 differing -> result = lane 0's word, no_majority_o=1, no further isolation.
REQ-045 Scenario 3: NUM_LANES=5, lanes 1 and 3 reach threshold on the same sample -> lane 1 isolated that cycle, lane 3 on the next disagreeing sample.
REQ-046 Scenario 4: err_ready_i held 0 while a second isolation occurs -> err_overflow_o=1, err_lane_o unchanged.
REQ-047 Scenario 5: clear_i and a threshold-crossing sample in the same cycle -> counters=0, no isolation, result_o still the voted word.
REQ-048 Scenario 6: BYPASS mode with lane 0 faulty -> result_o = lane 0's word, counters unchanged; rst mid-PEND -> err_valid_o=0 next cycle.
